// File: rtl/clk_pkg.sv
// Shared types and constants for the run/halt/step clock-enable controller.
package clk_pkg;

  // Controller state, also exported on the state port.
  typedef enum logic [1:0] {
    ST_HALT = 2'd0,
    ST_RUN  = 2'd1,
    ST_STEP = 2'd2
  } clk_state_e;

  // Command encoding on the cmd port; RSVD is accepted and ignored.
  typedef enum logic [1:0] {
    CMD_HALT = 2'd0,
    CMD_RUN  = 2'd1,
    CMD_STEP = 2'd2,
    CMD_RSVD = 2'd3
  } clk_cmd_e;

  localparam int unsigned CLK_DEFAULT_DIV = 32'd50000000;

endpackage

// File: rtl/clkdiv_rt.sv
// Runtime-programmable divider counter. wrap and half are decoded from the
// counter and the enable/divider registers feeding it, so neither has a
// combinational path from the command inputs.
module clkdiv_rt #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] div,
  output logic         wrap,
  output logic         half
);

  logic [W-1:0] cnt_reg;
  logic [W-1:0] div_eff;
  logic [W-1:0] last;
  logic [W:0]   half_len;

  // A divider of 0 behaves as 1; half_len is ceil(div_eff/2) computed one bit wider.
  always_comb begin
    div_eff  = (div == '0) ? W'(1) : div;
    last     = div_eff - W'(1);
    half_len = ({1'b0, div_eff} + (W+1)'(1)) >> 1;
  end

  assign wrap = en && (cnt_reg == last);
  assign half = en && ({1'b0, cnt_reg} < half_len);

  // Counter sits at 0 while disabled and restarts from 0 on clr.
  always_ff @(posedge clk) begin
    if (rst || clr || !en) begin
      cnt_reg <= '0;
    end else if (cnt_reg == last) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + W'(1);
    end
  end

endmodule

// File: rtl/clkctl.sv
// Run/halt/step controller for the core clock-enable: owns the divider value,
// the command FSM, the remaining-step counter and the done pulse.
module clkctl
  import clk_pkg::*;
#(
  parameter int          W           = 32,
  parameter int unsigned DEFAULT_DIV = CLK_DEFAULT_DIV,
  parameter int          SW          = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [W-1:0]  div_in,
  input  logic          div_load,
  input  logic          cmd_valid,
  input  logic [1:0]    cmd,
  input  logic [SW-1:0] cmd_steps,
  output logic          cmd_ready,
  input  logic          abort,
  output logic          tick,
  output logic          phase,
  output logic          done,
  output logic [1:0]    state,
  output logic [SW-1:0] steps_left
);

  clk_state_e    state_reg;
  logic [SW-1:0] rem_reg;
  logic          done_reg;
  logic [W-1:0]  div_reg;
  logic          accept;
  logic          cnt_clr;
  clk_cmd_e      cmd_e;

  assign cmd_e      = clk_cmd_e'(cmd);
  assign cmd_ready  = (state_reg != ST_STEP);
  assign accept     = cmd_valid && cmd_ready;
  // Entering STEP from RUN must restart the period; every other entry
  // already finds the counter parked at 0 because HALT disables it.
  assign cnt_clr    = abort || (accept && cmd_e == CMD_STEP);
  assign state      = state_reg;
  assign steps_left = rem_reg;
  assign done       = done_reg;

  clkdiv_rt #(.W(W)) u_div (
    .clk  (clk),
    .rst  (rst),
    .en   (state_reg != ST_HALT),
    .clr  (cnt_clr),
    .div  (div_reg),
    .wrap (tick),
    .half (phase)
  );

  // Command FSM with registered state, remaining-step count, done and divider.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_HALT;
      rem_reg   <= '0;
      done_reg  <= 1'b0;
      div_reg   <= W'(DEFAULT_DIV);
    end else begin
      done_reg <= 1'b0;
      // Divider may only change while the counter is parked.
      if (div_load && state_reg == ST_HALT) begin
        div_reg <= div_in;
      end
      if (abort) begin
        state_reg <= ST_HALT;
        rem_reg   <= '0;
      end else begin
        case (state_reg)
          ST_HALT: begin
            if (accept) begin
              case (cmd_e)
                CMD_RUN:  state_reg <= ST_RUN;
                CMD_STEP: begin
                  if (cmd_steps != '0) begin
                    state_reg <= ST_STEP;
                    rem_reg   <= cmd_steps;
                  end else begin
                    done_reg <= 1'b1;
                  end
                end
                default: ;
              endcase
            end
          end
          ST_RUN: begin
            if (accept) begin
              case (cmd_e)
                CMD_HALT: state_reg <= ST_HALT;
                CMD_STEP: begin
                  if (cmd_steps != '0) begin
                    state_reg <= ST_STEP;
                    rem_reg   <= cmd_steps;
                  end else begin
                    state_reg <= ST_HALT;
                    done_reg  <= 1'b1;
                  end
                end
                default: ;
              endcase
            end
          end
          ST_STEP: begin
            if (tick) begin
              if (rem_reg == SW'(1)) begin
                state_reg <= ST_HALT;
                rem_reg   <= '0;
                done_reg  <= 1'b1;
              end else begin
                rem_reg <= rem_reg - SW'(1);
              end
            end
          end
          default: state_reg <= ST_HALT;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_clkctl.sv
// Directed bench for clkctl: hand-computed tick/phase/done/state sequences.
module tb_clkctl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] div_in;
  logic        div_load;
  logic        cmd_valid;
  logic [1:0]  cmd;
  logic [15:0] cmd_steps;
  logic        cmd_ready;
  logic        abort;
  logic        tick;
  logic        phase;
  logic        done;
  logic [1:0]  state;
  logic [15:0] steps_left;

  int total = 0;
  int bad   = 0;

  clkctl dut (
    .clk        (clk),
    .rst        (rst),
    .div_in     (div_in),
    .div_load   (div_load),
    .cmd_valid  (cmd_valid),
    .cmd        (cmd),
    .cmd_steps  (cmd_steps),
    .cmd_ready  (cmd_ready),
    .abort      (abort),
    .tick       (tick),
    .phase      (phase),
    .done       (done),
    .state      (state),
    .steps_left (steps_left)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Called at a falling edge; presents one command for one clock and
  // returns at the falling edge of the cycle after the handshake edge.
  task automatic do_cmd(input logic [1:0] c, input logic [15:0] n,
                        input logic ld, input logic [31:0] dv);
    $display("cmd=%0d steps=%0d load=%0d div=%0d", c, n, ld, dv);
    cmd_valid = 1'b1;
    cmd       = c;
    cmd_steps = n;
    div_load  = ld;
    div_in    = dv;
    @(negedge clk);
    cmd_valid = 1'b0;
    div_load  = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_state"}, 32'(state), 32'd0);
    check_val({tag, "_tick"},  32'(tick),  32'd0);
    check_val({tag, "_phase"}, 32'(phase), 32'd0);
    check_val({tag, "_done"},  32'(done),  32'd0);
    check_val({tag, "_ready"}, 32'(cmd_ready), 32'd1);
    check_val({tag, "_steps"}, 32'(steps_left), 32'd0);
    check_val({tag, "_div"},   dut.div_reg, 32'd50000000);
  endtask

  initial begin
    rst = 1'b1; div_in = '0; div_load = 1'b0; cmd_valid = 1'b0;
    cmd = '0; cmd_steps = '0; abort = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_reset_outputs("reset");

    // RUN at div 4: ticks at k+4, k+8, k+12; phase high for cnt 0,1.
    do_cmd(2'd1, 16'd0, 1'b1, 32'd4);
    check_val("run4_state", 32'(state), 32'd1);
    for (int i = 1; i <= 12; i++) begin
      check_val($sformatf("run4_tick_%0d", i), 32'(tick), 32'((i % 4) == 0));
      check_val($sformatf("run4_phase_%0d", i), 32'(phase), 32'(((i - 1) % 4) < 2));
      @(negedge clk);
    end

    // div_load while running is dropped; period stays 4 (cnt is 0 here).
    $display("load div=7 during RUN");
    div_load = 1'b1; div_in = 32'd7;
    @(negedge clk);
    div_load = 1'b0;
    for (int j = 1; j <= 8; j++) begin
      check_val($sformatf("runload_tick_%0d", j), 32'(tick), 32'((j % 4) == 3));
      @(negedge clk);
    end
    check_val("runload_div", dut.div_reg, 32'd4);

    do_cmd(2'd0, 16'd0, 1'b0, 32'd0);
    check_val("halt_state", 32'(state), 32'd0);
    check_val("halt_tick", 32'(tick), 32'd0);
    check_val("halt_phase", 32'(phase), 32'd0);

    // Load 7 in HALT, then RUN: period 7, phase high for cnt 0..3.
    $display("load div=7 in HALT");
    div_load = 1'b1; div_in = 32'd7;
    @(negedge clk);
    div_load = 1'b0;
    do_cmd(2'd1, 16'd0, 1'b0, 32'd0);
    for (int i = 1; i <= 14; i++) begin
      check_val($sformatf("run7_tick_%0d", i), 32'(tick), 32'((i % 7) == 0));
      check_val($sformatf("run7_phase_%0d", i), 32'(phase), 32'(((i - 1) % 7) < 4));
      @(negedge clk);
    end
    do_cmd(2'd0, 16'd0, 1'b0, 32'd0);

    // STEP 5 with div 3 loaded in the same cycle.
    do_cmd(2'd2, 16'd5, 1'b1, 32'd3);
    for (int i = 1; i <= 17; i++) begin
      check_val($sformatf("step5_tick_%0d", i), 32'(tick), 32'(((i % 3) == 0) && (i <= 15)));
      check_val($sformatf("step5_done_%0d", i), 32'(done), 32'(i == 16));
      check_val($sformatf("step5_ready_%0d", i), 32'(cmd_ready), 32'(i > 15));
      check_val($sformatf("step5_state_%0d", i), 32'(state), (i <= 15) ? 32'd2 : 32'd0);
      check_val($sformatf("step5_rem_%0d", i), 32'(steps_left),
                (i <= 15) ? 32'(5 - (i - 1) / 3) : 32'd0);
      @(negedge clk);
    end

    // STEP 0: done at k+1, no tick, stays in HALT.
    do_cmd(2'd2, 16'd0, 1'b0, 32'd0);
    check_val("step0_done", 32'(done), 32'd1);
    check_val("step0_state", 32'(state), 32'd0);
    check_val("step0_tick", 32'(tick), 32'd0);
    @(negedge clk);
    check_val("step0_done_off", 32'(done), 32'd0);

    // div 0 and div 1: tick every cycle from k+1.
    for (int d = 0; d <= 1; d++) begin
      do_cmd(2'd1, 16'd0, 1'b1, 32'(d));
      for (int i = 1; i <= 4; i++) begin
        check_val($sformatf("div%0d_tick_%0d", d, i), 32'(tick), 32'd1);
        check_val($sformatf("div%0d_phase_%0d", d, i), 32'(phase), 32'd1);
        @(negedge clk);
      end
      do_cmd(2'd0, 16'd0, 1'b0, 32'd0);
      check_val($sformatf("div%0d_halt_tick", d), 32'(tick), 32'd0);
    end

    // abort beats an accepted RUN in HALT: command dropped.
    $display("abort with RUN in HALT");
    abort = 1'b1; cmd_valid = 1'b1; cmd = 2'd1;
    @(negedge clk);
    abort = 1'b0; cmd_valid = 1'b0;
    check_val("abort_halt_state", 32'(state), 32'd0);

    // abort in STEP 10 after 2 ticks at div 2, RUN presented alongside.
    do_cmd(2'd2, 16'd10, 1'b1, 32'd2);
    for (int i = 1; i <= 4; i++) begin
      check_val($sformatf("abstep_tick_%0d", i), 32'(tick), 32'((i % 2) == 0));
      @(negedge clk);
    end
    check_val("abstep_rem", 32'(steps_left), 32'd8);
    check_val("abstep_state", 32'(state), 32'd2);
    $display("abort in STEP");
    abort = 1'b1; cmd_valid = 1'b1; cmd = 2'd1;
    @(negedge clk);
    abort = 1'b0; cmd_valid = 1'b0;
    check_val("abort_state", 32'(state), 32'd0);
    check_val("abort_rem", 32'(steps_left), 32'd0);
    check_val("abort_done", 32'(done), 32'd0);
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      check_val($sformatf("abort_after_state_%0d", i), 32'(state), 32'd0);
      check_val($sformatf("abort_after_tick_%0d", i), 32'(tick), 32'd0);
      check_val($sformatf("abort_after_done_%0d", i), 32'(done), 32'd0);
    end

    // Reset mid-STEP with 6 steps remaining.
    do_cmd(2'd2, 16'd8, 1'b0, 32'd0);
    for (int i = 1; i <= 4; i++) @(negedge clk);
    check_val("rststep_rem", 32'(steps_left), 32'd6);
    $display("reset mid-STEP");
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset_outputs("midrst");
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      check_val($sformatf("midrst_done_%0d", i), 32'(done), 32'd0);
      check_val($sformatf("midrst_tick_%0d", i), 32'(tick), 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
